// File: rtl/seqdet_pkg.sv
// Shared types for the serial sequence detector: combine-mode enum and the
// flag combine function used by the top level.
package seqdet_pkg;

    typedef enum logic [1:0] {
        MODE_RUN = 2'd0,
        MODE_PAT = 2'd1,
        MODE_OR  = 2'd2,
        MODE_AND = 2'd3
    } mode_t;

    function automatic logic seqdet_combine(
        input mode_t mode,
        input logic  z_run,
        input logic  z_pat
    );
        logic z;
        case (mode)
            MODE_RUN: z = z_run;
            MODE_PAT: z = z_pat;
            MODE_OR:  z = z_run | z_pat;
            default:  z = z_run & z_pat;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/seqdet_pattern_match.sv
// Overlapping PAT_LEN-bit pattern matcher: history shift register, fill counter
// and registered z_pat flag. z_pat_nxt is the flag value the current sample would load.
module seqdet_pattern_match #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic En,
    input  logic Clear,
    input  logic w,
    output logic z_pat,
    output logic z_pat_nxt
);

    localparam int                FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_z_pat;

    logic [PAT_LEN-1:0] w_hist_nxt;
    logic [FILL_W-1:0]  w_fill_nxt;

    assign w_hist_nxt = {r_hist[PAT_LEN-2:0], w};
    assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
    // The fill gate keeps reset zeros in the history from matching an all-zero pattern.
    assign z_pat_nxt  = (w_fill_nxt == FILL_MAX) && (w_hist_nxt == PATTERN);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_z_pat <= 1'b0;
        end else if (Clear) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_z_pat <= 1'b0;
        end else if (En) begin
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_z_pat <= z_pat_nxt;
        end
    end

    assign z_pat = r_z_pat;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial run/pattern detector with selectable combine mode.
// Define SEQDET_HITCNT_EN to add the saturating HitCount port and counter.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                 RUN_LEN = 4,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         En,
    input  logic                         Clear,
    input  logic                         w,
    input  mode_t                        Mode,
    output logic                         z,
    output logic                         z_run,
    output logic                         z_pat,
    output logic [$clog2(RUN_LEN+1)-1:0] RunCount
`ifdef SEQDET_HITCNT_EN
    ,
    output logic [CNT_W-1:0]             HitCount
`endif
);

    localparam int               RUN_W   = $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    generate
        if (RUN_LEN < 1 || PAT_LEN < 2 || CNT_W < 1) begin : g_bad_param
            $error("seq_detector_param: need RUN_LEN>=1, PAT_LEN>=2, CNT_W>=1");
        end
    endgenerate

    logic [RUN_W-1:0] r_run_cnt;
    logic             r_z_run;
    logic [RUN_W-1:0] w_run_nxt;
    logic             w_z_run_nxt;
    logic             w_z_pat;
    logic             w_z_pat_nxt;

    assign w_run_nxt   = !w ? '0 : ((r_run_cnt == RUN_MAX) ? r_run_cnt : r_run_cnt + 1'b1);
    assign w_z_run_nxt = (w_run_nxt == RUN_MAX);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_run_cnt <= '0;
            r_z_run   <= 1'b0;
        end else if (Clear) begin
            r_run_cnt <= '0;
            r_z_run   <= 1'b0;
        end else if (En) begin
            r_run_cnt <= w_run_nxt;
            r_z_run   <= w_z_run_nxt;
        end
    end

    seqdet_pattern_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_pat (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .En        (En),
        .Clear     (Clear),
        .w         (w),
        .z_pat     (w_z_pat),
        .z_pat_nxt (w_z_pat_nxt)
    );

    // Mode acts only on the output mux, so switching it never disturbs detector history.
    assign z        = seqdet_combine(Mode, r_z_run, w_z_pat);
    assign z_run    = r_z_run;
    assign z_pat    = w_z_pat;
    assign RunCount = r_run_cnt;

`ifdef SEQDET_HITCNT_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic             w_hit;

    // A hit is the z value the current sample loads, judged under the present Mode.
    assign w_hit = seqdet_combine(Mode, w_z_run_nxt, w_z_pat_nxt);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_hit_cnt <= '0;
        end else if (Clear) begin
            r_hit_cnt <= '0;
        end else if (En && w_hit && (r_hit_cnt != {CNT_W{1'b1}})) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign HitCount = r_hit_cnt;
`endif

endmodule
